// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//  Types and constants shared between the instruction fetch unit and the
//  control decoder.
//   - fetch_state_e : fetch FSM states
//   - PC_SEQ/PC_REL/PC_REG : pc_src encodings produced by the decoder
//   - OP_BRANCH/OP_JAL/OP_JALR : opcodes of the control-flow instructions
//   - pc_is_aligned() : word-alignment check used on every next-PC target
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    // pc_src encodings; 2'b11 is unused by the decoder and falls back to sequential.
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic pc_is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
//  Purely combinational next-PC selection for the fetch unit.
//  Inputs : pc, pc_src, branch, jump, branch_taken, imm, rs1_data
//  Outputs: next_pc    - selected target (all adds modulo 2^32)
//           misaligned - target is not word aligned
// -----------------------------------------------------------------------------
module next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic        branch,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_target;
    logic [31:0] rel_target;
    logic [31:0] reg_target;
    logic        rel_taken;

    assign seq_target = pc + 32'd4;
    assign rel_target = pc + imm;
    // JALR semantics: bit 0 of the computed base+offset is always dropped.
    assign reg_target = (rs1_data + imm) & ~32'd1;
    // A pc-relative source only redirects for jumps or taken branches.
    assign rel_taken  = jump | (branch & branch_taken);

    always_comb begin
        next_pc = seq_target;
        if (pc_src == PC_REG) begin
            next_pc = reg_target;
        end else if ((pc_src == PC_REL) && rel_taken) begin
            next_pc = rel_target;
        end
    end

    assign misaligned = ~pc_is_aligned(next_pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//  Owns the PC, fetches one 32-bit instruction at a time over a valid/ready
//  instruction-memory port, holds it (with decoded opcode/funct3/funct7) until
//  the core retires it, then moves to the next PC chosen from the decoder's
//  branch/jump/pc_src outputs. A misaligned target raises a sticky fault.
//  Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr    fetch request channel
//   imem_rsp_valid, imem_rsp_data      fetch response channel
//   instr, instr_valid, pc             held instruction and its PC
//   opcode, funct3, funct7             fields of the held instruction
//   retire, branch, jump, pc_src,
//   branch_taken, imm, rs1_data        next-PC controls from the core
//   fetch_fault, fault_pc              sticky misaligned-target fault
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            retire,
    input  logic            branch,
    input  logic            jump,
    input  logic [1:0]      pc_src,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    next_pc_calc u_next_pc_calc (
        .pc           (pc_q),
        .pc_src       (pc_src),
        .branch       (branch),
        .jump         (jump),
        .branch_taken (branch_taken),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;

        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only this state listens to the response channel, so a
                // response can never arrive in the same cycle as its request.
                if (imem_rsp_valid) begin
                    instr_d       = imem_rsp_data;
                    instr_valid_d = 1'b1;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    instr_valid_d = 1'b0;
                    if (next_misaligned) begin
                        // PC stays on the instruction that produced the bad target.
                        fault_d    = 1'b1;
                        fault_pc_d = next_pc;
                        state_d    = S_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_FAULT: begin
                // Terminal until reset.
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    // Request is masked while rst is held so nothing is issued to memory
    // during any reset cycle (state_q is already S_REQ after the first one).
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_addr      = pc_q;

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign opcode      = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[31:25];
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        retire;
    logic        branch;
    logic        jump;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_asserts = 0;
    int n_fail    = 0;

    // Scoreboards: expected fetch addresses and expected captured instructions.
    logic [31:0] addr_sb[$];
    logic [31:0] instr_sb[$];
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .retire         (retire),
        .branch         (branch),
        .jump           (jump),
        .pc_src         (pc_src),
        .branch_taken   (branch_taken),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctrl();
        retire       = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        pc_src       = 2'b00;
        branch_taken = 1'b0;
        imm          = 32'h0;
        rs1_data     = 32'h0;
    endtask

    // Hold rst for one edge and check reset values; leaves rst low at a negedge.
    task automatic do_reset(input string tag);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        clear_ctrl();
        @(negedge clk);
        chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_fault"}, {31'h0, fetch_fault}, 32'h0);
        chk({tag, "_fault_pc"}, fault_pc, 32'h0);
        rst = 1'b0;
        addr_sb.delete();
        instr_sb.delete();
        addr_sb.push_back(32'h0);
        $display("reset %s: pc=%h instr_valid=%0b fault=%0b", tag, pc, instr_valid, fetch_fault);
    endtask

    // Wait (bounded) for a request and compare its address against the scoreboard.
    task automatic wait_req(input string tag, output logic [31:0] exp_addr);
        int n;
        n = 0;
        exp_addr = 32'hDEAD_BEEF;
        if (addr_sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h0, 32'h1);
        end else begin
            exp_addr = addr_sb.pop_front();
        end
        while (!imem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h1);
        chk({tag, "_req_addr"}, imem_addr, exp_addr);
    endtask

    // One full fetch: ready held low rdly cycles, response sdly cycles late.
    task automatic do_fetch(input string tag, input logic [31:0] data, input int rdly, input int sdly);
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        wait_req(tag, exp_addr);
        for (int i = 0; i < rdly; i++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_stall_addr"}, imem_addr, exp_addr);
            chk({tag, "_stall_valid"}, {31'h0, imem_req_valid}, 32'h1);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk({tag, "_wait_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        chk({tag, "_wait_instr_valid"}, {31'h0, instr_valid}, 32'h0);
        for (int i = 0; i < sdly; i++) begin
            @(negedge clk);
            chk({tag, "_late_instr_valid"}, {31'h0, instr_valid}, 32'h0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        instr_sb.push_back(data);
        @(negedge clk);
        // A further response while executing must not be captured.
        imem_rsp_data = ~data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        exp_instr = instr_sb.pop_front();
        chk({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h1);
        chk({tag, "_instr"}, instr, exp_instr);
        chk({tag, "_pc"}, pc, exp_addr);
        chk({tag, "_opcode"}, {25'h0, opcode}, {25'h0, exp_instr[6:0]});
        chk({tag, "_funct3"}, {29'h0, funct3}, {29'h0, exp_instr[14:12]});
        chk({tag, "_funct7"}, {25'h0, funct7}, {25'h0, exp_instr[31:25]});
        model_pc = exp_addr;
        $display("fetch %s: addr=%h instr=%h instr_valid=%0b", tag, imem_addr, instr, instr_valid);
    endtask

    // Retire the held instruction; exp_next is the hand-derived target.
    task automatic do_retire(input string tag, input logic [1:0] src, input logic br, input logic jp,
                             input logic tk, input logic [31:0] im, input logic [31:0] rs,
                             input logic [31:0] exp_next);
        retire       = 1'b1;
        pc_src       = src;
        branch       = br;
        jump         = jp;
        branch_taken = tk;
        imm          = im;
        rs1_data     = rs;
        @(negedge clk);
        clear_ctrl();
        chk({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
        if (exp_next[1:0] != 2'b00) begin
            chk({tag, "_fault"}, {31'h0, fetch_fault}, 32'h1);
            chk({tag, "_fault_pc"}, fault_pc, exp_next);
            chk({tag, "_pc_hold"}, pc, model_pc);
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_no_req"}, {31'h0, imem_req_valid}, 32'h0);
                imem_req_ready = 1'b1;
                @(negedge clk);
            end
            imem_req_ready = 1'b0;
            chk({tag, "_fault_sticky"}, {31'h0, fetch_fault}, 32'h1);
        end else begin
            chk({tag, "_fault"}, {31'h0, fetch_fault}, 32'h0);
            chk({tag, "_pc"}, pc, exp_next);
            addr_sb.push_back(exp_next);
        end
        $display("retire %s: pc=%h fault=%0b fault_pc=%h", tag, pc, fetch_fault, fault_pc);
    endtask

    initial begin
        logic [31:0] a;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        model_pc       = 32'h0;
        clear_ctrl();
        @(negedge clk);

        // 1: reset then zero-wait fetch of a NOP at address 0
        do_reset("t1_rst");
        do_fetch("t1_nop", 32'h0000_0013, 0, 0);

        // 2: jump to 0x100, sequential retire to 0x104
        do_retire("t2_jalr", 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h100);
        do_fetch("t2_f100", 32'h0020_80B3, 0, 0);
        do_retire("t2_seq", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h104);
        do_fetch("t2_f104", 32'h0000_0013, 0, 0);

        // 3: branch at 0x200, imm=-8, taken and not taken; pc_src=11 is sequential
        do_retire("t3_to200", 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h200);
        do_fetch("t3_br_a", 32'hFE00_0CE3, 0, 0);
        do_retire("t3_taken", 2'b01, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h1F8);
        do_fetch("t3_f1f8", 32'h0000_0013, 0, 0);
        do_retire("t3_back", 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h200);
        do_fetch("t3_br_b", 32'hFE00_0CE3, 0, 0);
        do_retire("t3_ntaken", 2'b01, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h204);
        do_fetch("t3_f204", 32'h4000_5033, 0, 0);
        do_retire("t3_src11", 2'b11, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 32'h208);
        do_fetch("t3_f208", 32'h0000_0013, 0, 0);

        // 4a: JALR rs1=0x1001 imm=2 -> 0x1002 (bit0 cleared), misaligned -> fault
        do_retire("t4_jalr", 2'b10, 1'b0, 1'b1, 1'b0, 32'h2, 32'h1001, 32'h1002);

        // 5: stalled request and late response after a reset that clears the fault
        do_reset("t5_rst");
        do_fetch("t5_slow", 32'h0000_006F, 3, 2);

        // 4b: JAL imm=6 from pc 0 -> fault at 0x6
        do_retire("t4_jal", 2'b01, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0, 32'h6);

        // 6: reset in S_WAIT and in S_EXEC
        do_reset("t6_rst0");
        wait_req("t6_wait", a);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        do_reset("t6_rst_wait");
        do_fetch("t6_exec", 32'h0000_0013, 0, 0);
        do_reset("t6_rst_exec");
        do_fetch("t6_f0", 32'h0000_0013, 0, 0);

        // 6b: sequential wrap from 0xFFFFFFFC to 0
        do_retire("t6_tomax", 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        do_fetch("t6_fmax", 32'h0000_0013, 0, 0);
        do_retire("t6_wrap", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        do_fetch("t6_f0b", 32'h0000_0013, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
